// File: rtl/fft_pkg.sv
// fft_pkg: shared frame geometry, pipeline latencies and FSM state encoding
// for the FFT stage sequencer and its validity pipeline.
package fft_pkg;
    localparam int N_PTS     = 128;
    localparam int LANES     = 4;
    localparam int FRAME_LEN = N_PTS / LANES;
    localparam int CNT_W     = $clog2(FRAME_LEN);
    localparam int S2_LAT    = 17;
    localparam int OUT_LAT   = 19;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
endpackage

// File: rtl/fft_stage_sequencer_if.sv
// fft_stage_sequencer_if: sample-quad framing inputs and datapath control outputs.
//   in_valid/in_sof         : quad present / first quad of a frame
//   ctrl_s1, ctrl_s2, twd_s2: butterfly and rotation selects for stages 1 and 2
//   coeff_en, coeff_addr    : twiddle multiplier enable and ROM index
//   out_valid/out_sof       : FFT output qualifiers
//   frame_err, busy         : framing violation pulse / sequencer not idle
// master drives the framing inputs; slave is the sequencer.
interface fft_stage_sequencer_if #(parameter int AW = fft_pkg::CNT_W);
    logic          in_valid;
    logic          in_sof;
    logic          ctrl_s1;
    logic          ctrl_s2;
    logic          twd_s2;
    logic          coeff_en;
    logic [AW-1:0] coeff_addr;
    logic          out_valid;
    logic          out_sof;
    logic          frame_err;
    logic          busy;
    modport master (
        output in_valid, in_sof,
        input  ctrl_s1, ctrl_s2, twd_s2, coeff_en, coeff_addr, out_valid, out_sof, frame_err, busy
    );
    modport slave (
        input  in_valid, in_sof,
        output ctrl_s1, ctrl_s2, twd_s2, coeff_en, coeff_addr, out_valid, out_sof, frame_err, busy
    );
endinterface

// File: rtl/fft_valid_pipe.sv
// fft_valid_pipe: shift register of accepted-quad and sof flags with a mid tap.
//   clk, rst         : clock, synchronous active-high reset (clears all flags)
//   in_vld, in_sof   : flags for the quad accepted this cycle
//   tap_vld, tap_sof : flags TAP cycles after acceptance
//   out_vld, out_sof : flags DEPTH cycles after acceptance
//   empty            : no accepted quad anywhere in the pipe
module fft_valid_pipe #(
    parameter int DEPTH = 19,
    parameter int TAP   = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic in_vld,
    input  logic in_sof,
    output logic tap_vld,
    output logic tap_sof,
    output logic out_vld,
    output logic out_sof,
    output logic empty
);
    logic [DEPTH:1] vld, sof;
    always_ff @(posedge clk) begin
        if (rst) begin
            vld <= '0;
            sof <= '0;
        end else begin
            vld <= {vld[DEPTH-1:1], in_vld};
            sof <= {sof[DEPTH-1:1], in_vld & in_sof};
        end
    end
    assign tap_vld = vld[TAP];
    assign tap_sof = sof[TAP];
    assign out_vld = vld[DEPTH];
    assign out_sof = sof[DEPTH];
    assign empty   = ~|vld;
endmodule

// File: rtl/fft_stage_sequencer.sv
// fft_stage_sequencer: frame FSM and control generation for a two-stage FFT datapath.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of fft_stage_sequencer_if (framing in, control/qualifiers out)
// Every output is a flop; a quad accepted in cycle t shows ctrl_s1 at t+1,
// stage-2 selects at t+S2_LAT, coeff_en/coeff_addr at t+S2_LAT+1, out_valid at t+OUT_LAT.
module fft_stage_sequencer #(
    parameter int N_PTS   = fft_pkg::N_PTS,
    parameter int LANES   = fft_pkg::LANES,
    parameter int S2_LAT  = fft_pkg::S2_LAT,
    parameter int OUT_LAT = fft_pkg::OUT_LAT
) (
    input logic clk,
    input logic rst,
    fft_stage_sequencer_if.slave bus
);
    import fft_pkg::*;
    localparam int FLEN = N_PTS / LANES;
    localparam int CW   = $clog2(FLEN);
    state_t state;
    logic [CW-1:0] in_cnt, s2_cnt, s2_idx, idx_in, idx_s2;
    logic start, cont, accept, s2_vld, tap_vld, tap_sof, pipe_empty;
    // A frame may start from IDLE/DRAIN, or in RUN exactly when the previous frame just completed.
    always_comb begin
        start  = bus.in_valid & bus.in_sof & ((state != RUN) | (in_cnt == '0));
        cont   = (state == RUN) & (in_cnt != '0) & bus.in_valid & ~bus.in_sof;
        accept = start | cont;
        idx_in = start ? '0 : in_cnt;
        idx_s2 = tap_sof ? '0 : s2_cnt;
    end
    // Tap one cycle early so the registered stage-2 selects line up with stage-2 entry.
    fft_valid_pipe #(.DEPTH(OUT_LAT), .TAP(S2_LAT - 1)) u_pipe (
        .clk    (clk),
        .rst    (rst),
        .in_vld (accept),
        .in_sof (start),
        .tap_vld(tap_vld),
        .tap_sof(tap_sof),
        .out_vld(bus.out_valid),
        .out_sof(bus.out_sof),
        .empty  (pipe_empty)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            in_cnt         <= '0;
            s2_cnt         <= '0;
            s2_idx         <= '0;
            s2_vld         <= 1'b0;
            bus.ctrl_s1    <= 1'b0;
            bus.coeff_en   <= 1'b0;
            bus.coeff_addr <= '0;
            bus.frame_err  <= 1'b0;
            bus.busy       <= 1'b0;
        end else begin
            in_cnt        <= accept ? idx_in + 1'b1 : '0;
            state         <= accept ? RUN : (state == RUN) ? DRAIN : (state == DRAIN && pipe_empty) ? IDLE : state;
            bus.frame_err <= (state == RUN) & ~accept & ((in_cnt != '0) | bus.in_valid);
            bus.busy      <= accept | (state == RUN) | ((state == DRAIN) & ~pipe_empty);
            bus.ctrl_s1   <= accept & idx_in[CW-1];
            if (tap_vld) begin
                s2_cnt <= idx_s2 + 1'b1;
                s2_idx <= idx_s2;
            end
            s2_vld       <= tap_vld;
            bus.coeff_en <= s2_vld;
            if (s2_vld) bus.coeff_addr <= s2_idx;
        end
    end
    assign bus.ctrl_s2 = s2_idx[CW-1];
    assign bus.twd_s2  = s2_idx[CW-2];
endmodule

// File: tb/tb_fft_stage_sequencer.sv
// tb_fft_stage_sequencer: directed framing scenarios plus randomized traffic,
// checked every cycle against a frame-level reference model.
module tb_fft_stage_sequencer;
    import fft_pkg::*;
    localparam int MAXC = 12000;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    fft_stage_sequencer_if bus ();
    fft_stage_sequencer dut (.clk(clk), .rst(rst), .bus(bus));
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    // Reference model: which cycles accepted a quad and that quad's position in its frame.
    bit acc [MAXC];
    int aidx [MAXC];
    int last_rst = -1;
    bit running = 0;
    int pos = 0;
    int m_s2 = 0;
    int m_ca = 0;
    bit m_busy = 0;
    function automatic bit valid_at(input int a);
        return a >= 0 && a > last_rst && acc[a];
    endfunction
    function automatic int idx_at(input int a);
        return valid_at(a) ? aidx[a] : 0;
    endfunction
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
        end
    endtask
    task automatic step(input bit v, input bit s, input bit r);
        bit e;
        bit ne;
        int n;
        bus.in_valid = v;
        bus.in_sof = s;
        rst = r;
        @(posedge clk);
        #1;
        e = 0;
        acc[cyc] = 0;
        if (r) begin
            running = 0;
            pos = 0;
            last_rst = cyc;
        end else if (v && s && (!running || pos == FRAME_LEN)) begin
            acc[cyc] = 1;
            aidx[cyc] = 0;
            running = 1;
            pos = 1;
        end else if (v && !s && running && pos < FRAME_LEN) begin
            acc[cyc] = 1;
            aidx[cyc] = pos;
            pos++;
        end else if (running) begin
            e = v || pos < FRAME_LEN;
            running = 0;
        end
        ne = 0;
        for (int k = 1; k <= OUT_LAT; k++) if (valid_at(cyc - k)) ne = 1;
        m_busy = !r && (running || (m_busy && ne));
        n = cyc + 1;
        if (r) begin
            m_s2 = 0;
            m_ca = 0;
        end else begin
            if (valid_at(n - S2_LAT)) m_s2 = aidx[n - S2_LAT];
            if (valid_at(n - S2_LAT - 1)) m_ca = aidx[n - S2_LAT - 1];
        end
        chk("out_valid", bus.out_valid, valid_at(n - OUT_LAT));
        chk("out_sof", bus.out_sof, valid_at(n - OUT_LAT) && idx_at(n - OUT_LAT) == 0);
        chk("ctrl_s1", bus.ctrl_s1, valid_at(cyc) && idx_at(cyc) >= 16);
        chk("ctrl_s2", bus.ctrl_s2, m_s2 >= 16);
        chk("twd_s2", bus.twd_s2, (m_s2 >> 3) & 1);
        chk("coeff_en", bus.coeff_en, valid_at(n - S2_LAT - 1));
        chk("coeff_addr", bus.coeff_addr, m_ca);
        chk("frame_err", bus.frame_err, e);
        chk("busy", bus.busy, m_busy);
        cyc++;
    endtask
    task automatic idle(input int k);
        for (int i = 0; i < k; i++) step(0, 0, 0);
    endtask
    // stop_at < FRAME_LEN truncates the frame there, either by dropping valid or by a stray sof.
    task automatic send_frame(input int stop_at, input bit sof_err);
        for (int i = 0; i < FRAME_LEN; i++) begin
            if (i == stop_at) begin
                step(sof_err, sof_err, 0);
                return;
            end
            step(1, i == 0, 0);
        end
    endtask
    initial begin
        bus.in_valid = 0;
        bus.in_sof = 0;
        step(1, 1, 1);
        step(0, 0, 1);
        step(1, 0, 0);
        send_frame(FRAME_LEN, 0);
        idle(40);
        for (int f = 0; f < 3; f++) send_frame(FRAME_LEN, 0);
        idle(40);
        send_frame(10, 0);
        idle(40);
        send_frame(20, 1);
        idle(40);
        send_frame(25, 0);
        step(1, 0, 1);
        idle(2);
        send_frame(FRAME_LEN, 0);
        idle(40);
        send_frame(FRAME_LEN, 0);
        idle(4);
        send_frame(FRAME_LEN, 0);
        step(1, 0, 0);
        idle(40);
        for (int ep = 0; ep < 60 && cyc < MAXC - 200; ep++) begin
            case ($urandom_range(0, 5))
                0, 1: for (int f = 0; f <= $urandom_range(0, 2); f++) send_frame(FRAME_LEN, 0);
                2: send_frame($urandom_range(1, FRAME_LEN - 1), 1'($urandom_range(0, 1)));
                3: for (int i = 0; i < $urandom_range(0, 25); i++) begin
                    bit v;
                    v = 1'($urandom_range(0, 1));
                    step(v, v && $urandom_range(0, 7) == 0, 0);
                end
                4: begin
                    send_frame($urandom_range(1, FRAME_LEN), 0);
                    step(1'($urandom_range(0, 1)), 0, 1);
                end
                default: begin
                    send_frame(FRAME_LEN, 0);
                    step(1, 0, 0);
                end
            endcase
            idle($urandom_range(0, 22));
        end
        idle(40);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
